// File: rtl/riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu
// Description : 5-stage in-order RV32 core (ADDI/ADD/SUB/LW/SW/BEQ) with
//               internal instruction memory, register file and data memory.
//               The MUL instruction is added when the RV_MUL_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module rv_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);
    logic [31:0] PC;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            PC <= RESET_PC;
        end else if (i_redirect) begin
            PC <= i_target;
        end else if (!i_hold) begin
            PC <= PC + 32'd4;
        end
    end

    assign o_pc = PC;
endmodule

module rv_imem #(
    parameter int IMEM_WORDS = 256
) (
    input  logic                          i_clock,
    input  logic [31:0]                   i_addr,
    input  logic                          i_wr_en,
    input  logic [$clog2(IMEM_WORDS)-1:0] i_wr_addr,
    input  logic [31:0]                   i_wr_data,
    output logic [31:0]                   o_instr
);
    localparam int c_IDX_W = $clog2(IMEM_WORDS);

    logic [31:0] IMem [IMEM_WORDS];
    logic        w_unused;

    // Program-load port; the core itself never writes instruction memory.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            IMem[i_wr_addr] <= i_wr_data;
        end
    end

    // Dropping the upper PC bits makes out-of-range fetches wrap.
    assign o_instr  = IMem[i_addr[c_IDX_W+1:2]];
    assign w_unused = ^{i_addr[31:c_IDX_W+2], i_addr[1:0]};
endmodule

module rv_regfile (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);
    logic [31:0] Regs [32];
    logic        w_wr_live;

    assign w_wr_live = i_wr_en && (i_wr_addr != 5'd0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                Regs[i] <= 32'(i);
            end
        end else if (w_wr_live) begin
            Regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs1_data = (w_wr_live && i_wr_addr == i_rs1) ? i_wr_data : Regs[i_rs1];
    assign o_rs2_data = (w_wr_live && i_wr_addr == i_rs2) ? i_wr_data : Regs[i_rs2];
endmodule

module rv_main_memory #(
    parameter int DMEM_LINES = 1024
) (
    input  logic                          i_clock,
    input  logic [$clog2(DMEM_LINES)-1:0] i_line,
    input  logic [1:0]                    i_word,
    input  logic                          i_wr_en,
    input  logic [31:0]                   i_wr_data,
    output logic [31:0]                   o_rd_data
);
    logic [127:0] memArray [DMEM_LINES];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            memArray[i_line][{i_word, 5'b0} +: 32] <= i_wr_data;
        end
    end

    assign o_rd_data = memArray[i_line][{i_word, 5'b0} +: 32];
endmodule

module rv_mem_stage #(
    parameter int DMEM_LINES = 1024
) (
    input  logic        i_clock,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned
);
    localparam int c_LINE_W = $clog2(DMEM_LINES);

    logic w_unused;

    assign o_misaligned = (i_mem_read || i_mem_write) && (i_addr[1:0] != 2'b00);
    assign w_unused     = ^i_addr[31:c_LINE_W+4];

    rv_main_memory #(.DMEM_LINES(DMEM_LINES)) main_memory (
        .i_clock   (i_clock),
        .i_line    (i_addr[c_LINE_W+3:4]),
        .i_word    (i_addr[3:2]),
        .i_wr_en   (i_mem_write && !o_misaligned),
        .i_wr_data (i_wr_data),
        .o_rd_data (o_rd_data)
    );
endmodule

module riscv_cpu #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_LINES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clock,
    input logic reset
);
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0] c_ALU_ADD   = 2'd0;
    localparam logic [1:0] c_ALU_SUB   = 2'd1;
`ifdef RV_MUL_EN
    localparam logic [1:0] c_ALU_MUL   = 2'd2;
`endif

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_imm;
        logic [1:0] alu_op;
        logic       use_rs1;
        logic       use_rs2;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        reg_write;
    } mem_wb_t;

    if_id_t      if_id_bus_in, r_if_id;
    id_ex_t      id_ex_bus_in, r_id_ex;
    ex_mem_t     ex_mem_bus_in, r_ex_mem;
    mem_wb_t     mem_wb_bus_in, mem_wb_bus_out;
    ctrl_t       ctrl_signals;

    logic        halted;
    logic [31:0] exc_pc;
    logic [31:0] exc_cause;

    logic [31:0] w_pc, w_instr, w_imm, w_rs1_data, w_rs2_data;
    logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_target, w_load_data;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_exc, w_freeze, w_load_use, w_take, w_unused;

    assign w_freeze = halted || w_exc;

    // ---------------- IF ----------------
    rv_if_stage #(.RESET_PC(RESET_PC)) if_stage (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_hold     (w_freeze || w_load_use),
        .i_redirect (w_take && !w_freeze),
        .i_target   (w_target),
        .o_pc       (w_pc)
    );

    rv_imem #(.IMEM_WORDS(IMEM_WORDS)) imem (
        .i_clock   (clock),
        .i_addr    (w_pc),
        .i_wr_en   (1'b0),
        .i_wr_addr ('0),
        .i_wr_data (32'h0),
        .o_instr   (w_instr)
    );

    assign if_id_bus_in = '{pc: w_pc, instr: w_instr};

    // ---------------- ID ----------------
    assign w_opcode = r_if_id.instr[6:0];
    assign w_rd     = r_if_id.instr[11:7];
    assign w_funct3 = r_if_id.instr[14:12];
    assign w_rs1    = r_if_id.instr[19:15];
    assign w_rs2    = r_if_id.instr[24:20];
    assign w_funct7 = r_if_id.instr[31:25];

    always_comb begin
        ctrl_signals = '0;
        w_imm        = {{20{r_if_id.instr[31]}}, r_if_id.instr[31:20]};
        case (w_opcode)
            c_OP_IMM: begin
                if (w_funct3 == 3'b000) begin
                    ctrl_signals.reg_write = 1'b1;
                    ctrl_signals.alu_imm   = 1'b1;
                    ctrl_signals.use_rs1   = 1'b1;
                end
            end
            c_OP_REG: begin
                if (w_funct3 == 3'b000) begin
                    if (w_funct7 == 7'b0000000) begin
                        ctrl_signals.reg_write = 1'b1;
                    end else if (w_funct7 == 7'b0100000) begin
                        ctrl_signals.reg_write = 1'b1;
                        ctrl_signals.alu_op    = c_ALU_SUB;
`ifdef RV_MUL_EN
                    end else if (w_funct7 == 7'b0000001) begin
                        ctrl_signals.reg_write = 1'b1;
                        ctrl_signals.alu_op    = c_ALU_MUL;
`endif
                    end
                    ctrl_signals.use_rs1 = ctrl_signals.reg_write;
                    ctrl_signals.use_rs2 = ctrl_signals.reg_write;
                end
            end
            c_OP_LOAD: begin
                if (w_funct3 == 3'b010) begin
                    ctrl_signals.reg_write = 1'b1;
                    ctrl_signals.mem_read  = 1'b1;
                    ctrl_signals.alu_imm   = 1'b1;
                    ctrl_signals.use_rs1   = 1'b1;
                end
            end
            c_OP_STORE: begin
                w_imm = {{20{r_if_id.instr[31]}}, r_if_id.instr[31:25], r_if_id.instr[11:7]};
                if (w_funct3 == 3'b010) begin
                    ctrl_signals.mem_write = 1'b1;
                    ctrl_signals.alu_imm   = 1'b1;
                    ctrl_signals.use_rs1   = 1'b1;
                    ctrl_signals.use_rs2   = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                w_imm = {{19{r_if_id.instr[31]}}, r_if_id.instr[31], r_if_id.instr[7],
                         r_if_id.instr[30:25], r_if_id.instr[11:8], 1'b0};
                if (w_funct3 == 3'b000) begin
                    ctrl_signals.branch  = 1'b1;
                    ctrl_signals.use_rs1 = 1'b1;
                    ctrl_signals.use_rs2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    rv_regfile regfile (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_wr_en    (mem_wb_bus_out.reg_write),
        .i_wr_addr  (mem_wb_bus_out.rd),
        .i_wr_data  (mem_wb_bus_out.result)
    );

    // A load's data only exists after MEM, so its consumer must wait one cycle in ID.
    assign w_load_use = r_id_ex.ctrl.mem_read && (r_id_ex.rd != 5'd0) &&
                        ((ctrl_signals.use_rs1 && w_rs1 == r_id_ex.rd) ||
                         (ctrl_signals.use_rs2 && w_rs2 == r_id_ex.rd));

    assign id_ex_bus_in = '{pc: r_if_id.pc, rs1_val: w_rs1_data, rs2_val: w_rs2_data,
                            imm: w_imm, rs1: w_rs1, rs2: w_rs2, rd: w_rd,
                            ctrl: ctrl_signals};

    // ---------------- EX ----------------
    // MEM/WB first, EX/MEM second: the later assignment is the younger producer.
    always_comb begin
        w_fwd_a = r_id_ex.rs1_val;
        w_fwd_b = r_id_ex.rs2_val;
        if (mem_wb_bus_out.reg_write && mem_wb_bus_out.rd != 5'd0) begin
            if (mem_wb_bus_out.rd == r_id_ex.rs1) w_fwd_a = mem_wb_bus_out.result;
            if (mem_wb_bus_out.rd == r_id_ex.rs2) w_fwd_b = mem_wb_bus_out.result;
        end
        if (r_ex_mem.reg_write && !r_ex_mem.mem_read && r_ex_mem.rd != 5'd0) begin
            if (r_ex_mem.rd == r_id_ex.rs1) w_fwd_a = r_ex_mem.result;
            if (r_ex_mem.rd == r_id_ex.rs2) w_fwd_b = r_ex_mem.result;
        end
    end

    assign w_op_b = r_id_ex.ctrl.alu_imm ? r_id_ex.imm : w_fwd_b;

    always_comb begin
        case (r_id_ex.ctrl.alu_op)
            c_ALU_ADD: w_alu = w_fwd_a + w_op_b;
            c_ALU_SUB: w_alu = w_fwd_a - w_op_b;
`ifdef RV_MUL_EN
            c_ALU_MUL: w_alu = w_fwd_a * w_op_b;
`endif
            default:   w_alu = w_fwd_a + w_op_b;
        endcase
    end

    assign w_take   = r_id_ex.ctrl.branch && (w_fwd_a == w_fwd_b);
    assign w_target = r_id_ex.pc + r_id_ex.imm;

    assign ex_mem_bus_in = '{pc: r_id_ex.pc, result: w_alu, store_data: w_fwd_b,
                             rd: r_id_ex.rd, reg_write: r_id_ex.ctrl.reg_write,
                             mem_read: r_id_ex.ctrl.mem_read,
                             mem_write: r_id_ex.ctrl.mem_write};
    assign w_unused = ^{r_id_ex.ctrl.use_rs1, r_id_ex.ctrl.use_rs2};

    // ---------------- MEM ----------------
    rv_mem_stage #(.DMEM_LINES(DMEM_LINES)) mem_stage (
        .i_clock      (clock),
        .i_addr       (r_ex_mem.result),
        .i_wr_data    (r_ex_mem.store_data),
        .i_mem_read   (r_ex_mem.mem_read),
        .i_mem_write  (r_ex_mem.mem_write),
        .o_rd_data    (w_load_data),
        .o_misaligned (w_exc)
    );

    assign mem_wb_bus_in = '{rd: r_ex_mem.rd,
                             result: r_ex_mem.mem_read ? w_load_data : r_ex_mem.result,
                             reg_write: r_ex_mem.reg_write};

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_if_id        <= '0;
            r_id_ex        <= '0;
            r_ex_mem       <= '0;
            mem_wb_bus_out <= '0;
            halted         <= 1'b0;
            exc_pc         <= 32'h0;
            exc_cause      <= 32'h0;
        end else if (w_freeze) begin
            // The WB instruction still commits through the register file this edge.
            r_if_id        <= '0;
            r_id_ex        <= '0;
            r_ex_mem       <= '0;
            mem_wb_bus_out <= '0;
            if (w_exc) begin
                halted    <= 1'b1;
                exc_pc    <= r_ex_mem.pc;
                exc_cause <= r_ex_mem.mem_write ? 32'd6 : 32'd4;
            end
        end else begin
            mem_wb_bus_out <= mem_wb_bus_in;
            r_ex_mem       <= ex_mem_bus_in;
            if (w_take) begin
                r_if_id <= '0;
                r_id_ex <= '0;
            end else if (w_load_use) begin
                r_id_ex <= '0;
            end else begin
                r_if_id <= if_id_bus_in;
                r_id_ex <= id_ex_bus_in;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_cpu
// Description : Self-checking bench for riscv_cpu; a writeback scoreboard plus
//               end-of-program state checks (RV_MUL_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_riscv_cpu;
    localparam logic [31:0]  c_NOP     = 32'h0000_0013;
    localparam logic [31:0]  c_DRAIN   = 32'h0000_007F;
    localparam logic [127:0] c_PATTERN = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    typedef struct {
        int rd;
        int val;
        int cyc;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    wb_t         sb_q[$];
    logic [31:0] prog[$];
    logic [127:0] mem_exp;
    logic [31:0] pc_snap;

    riscv_cpu dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every committed non-x0 writeback must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && dut.regfile.i_wr_en && dut.regfile.i_wr_addr != 5'd0) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected_rd", {123'b0, dut.regfile.i_wr_addr}, 128'd0);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                check("wb_rd", {123'b0, dut.regfile.i_wr_addr}, 128'(e.rd));
                check("wb_val", {96'b0, dut.regfile.i_wr_data}, 128'(unsigned'(e.val)));
                check("wb_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] a_addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] a_lw(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 2, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] a_add(int rd, int rs1, int rs2);
        return enc_r(0, rs2, rs1, rd);
    endfunction
    function automatic logic [31:0] a_sub(int rd, int rs1, int rs2);
        return enc_r(32, rs2, rs1, rd);
    endfunction
    function automatic logic [31:0] a_mul(int rd, int rs1, int rs2);
        return enc_r(1, rs2, rs1, rd);
    endfunction
    function automatic logic [31:0] a_sw(int rs2, int rs1, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] a_beq(int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic push_wb(input int rd, input int val, input int at_cyc);
        sb_q.push_back('{rd: rd, val: val, cyc: at_cyc});
    endtask

    // Holds reset across two edges while the program is written.
    task automatic load_program();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.imem.IMem[i] = (i < prog.size()) ? prog[i] : c_DRAIN;
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reg(input string tag, input int r, input int exp);
        check(tag, {96'b0, dut.regfile.Regs[r]}, 128'(unsigned'(exp)));
    endtask

    initial begin
        // Program with a misaligned store that halts the core.
        sb_q.delete();
        prog = {a_addi(1, 0, 5), a_addi(2, 0, 3), a_sw(5, 0, 1), a_sub(4, 1, 2),
                a_mul(5, 1, 2), a_addi(6, 0, 100), a_add(7, 5, 6), a_add(3, 1, 2),
                c_NOP, c_NOP, c_DRAIN};
        dut.mem_stage.main_memory.memArray[0] = c_PATTERN;
        load_program();
        check("reset_pc", {96'b0, dut.if_stage.PC}, 128'd0);
        check("reset_halted", {127'b0, dut.halted}, 128'd0);
        push_wb(1, 5, 4);
        push_wb(2, 3, 5);
        run(50);
        for (int r = 1; r <= 7; r++) begin
            check_reg($sformatf("t1_x%0d", r), r, (r == 1) ? 5 : (r == 2) ? 3 : r);
        end
        check("t1_mem0", dut.mem_stage.main_memory.memArray[0], c_PATTERN);
        check("t1_exc_pc", {96'b0, dut.exc_pc}, 128'd8);
        check("t1_exc_cause", {96'b0, dut.exc_cause}, 128'd6);
        check("t1_halted", {127'b0, dut.halted}, 128'd1);
        check("t1_pc", {96'b0, dut.if_stage.PC}, 128'd20);
        pc_snap = dut.if_stage.PC;
        repeat (5) @(negedge clock);
        check("t1_pc_frozen", {96'b0, dut.if_stage.PC}, {96'b0, pc_snap});
        check("t1_sb_drained", 128'(sb_q.size()), 128'd0);

        // Same program with an aligned store: full forwarding chain.
        prog[2] = a_sw(1, 0, 0);
        dut.mem_stage.main_memory.memArray[0] = c_PATTERN;
        load_program();
        push_wb(1, 5, 4);
        push_wb(2, 3, 5);
        push_wb(4, 2, 7);
`ifdef RV_MUL_EN
        push_wb(5, 15, 8);
`endif
        push_wb(6, 100, 9);
`ifdef RV_MUL_EN
        push_wb(7, 115, 10);
`else
        push_wb(7, 105, 10);
`endif
        push_wb(3, 8, 11);
        run(50);
        check_reg("t2_x3", 3, 8);
        check_reg("t2_x4", 4, 2);
`ifdef RV_MUL_EN
        check_reg("t2_x5", 5, 15);
        check_reg("t2_x7", 7, 115);
`else
        check_reg("t2_x5", 5, 5);
        check_reg("t2_x7", 7, 105);
`endif
        check_reg("t2_x6", 6, 100);
        mem_exp = c_PATTERN;
        mem_exp[31:0] = 32'd5;
        check("t2_mem0", dut.mem_stage.main_memory.memArray[0], mem_exp);
        check("t2_halted", {127'b0, dut.halted}, 128'd0);
        check("t2_sb_drained", 128'(sb_q.size()), 128'd0);

        // Back-to-back dependency resolved by forwarding, no stall.
        prog = {a_addi(1, 0, 7), a_add(2, 1, 1)};
        load_program();
        push_wb(1, 7, 4);
        push_wb(2, 14, 5);
        run(20);
        check_reg("t3_x2", 2, 14);
        check("t3_sb_drained", 128'(sb_q.size()), 128'd0);

        // Load-use: exactly one bubble between lw and its consumer.
        mem_exp = c_PATTERN;
        mem_exp[63:32] = 32'd9;
        dut.mem_stage.main_memory.memArray[0] = mem_exp;
        prog = {a_lw(3, 0, 4), a_add(4, 3, 3)};
        load_program();
        push_wb(3, 9, 4);
        push_wb(4, 18, 6);
        run(20);
        check_reg("t4_x4", 4, 18);
        check("t4_sb_drained", 128'(sb_q.size()), 128'd0);

        // Taken branch skips addi; misaligned load at the target faults.
        prog = {a_beq(0, 0, 8), a_addi(9, 0, 1), a_lw(1, 0, 2)};
        load_program();
        run(30);
        check_reg("t5_x9", 9, 9);
        check_reg("t5_x1", 1, 1);
        check("t5_exc_cause", {96'b0, dut.exc_cause}, 128'd4);
        check("t5_exc_pc", {96'b0, dut.exc_pc}, 128'd8);
        check("t5_halted", {127'b0, dut.halted}, 128'd1);

        // One-cycle reset out of the halted state.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_pc", {96'b0, dut.if_stage.PC}, 128'd0);
        check("t6_halted", {127'b0, dut.halted}, 128'd0);
        check("t6_exc_pc", {96'b0, dut.exc_pc}, 128'd0);
        check("t6_exc_cause", {96'b0, dut.exc_cause}, 128'd0);
        for (int r = 0; r < 32; r++) begin
            check_reg($sformatf("t6_x%0d", r), r, r);
        end
        repeat (2) @(negedge clock);
        check("t6_restart_pc", {96'b0, dut.if_stage.PC}, 128'd8);
        check("t6_restart_halted", {127'b0, dut.halted}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
